// File: rtl/vga_pkg.sv
// Shared definitions for the VGA text display path.
// Holds the default 640x480@60 timing, the 24-bit colour type and the
// sync-polarity helpers used by the timing generator and its sub-blocks.
package vga_pkg;

    // Default 640x480@60 timing (pixels / lines)
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    // Standard VGA modes use active-low sync pulses
    localparam bit DEF_SYNC_NEG = 1'b1;

    typedef logic [23:0] rgb24_t;

    // Counter width that never collapses to zero bits
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Pin level for an active-high internal sync flag
    function automatic logic sync_level(input logic act, input bit neg);
        return act ^ neg;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH shift register with synchronous active-high reset.
// Aligns stage-0 control with data returning from VRAM/font ROM.
// DEPTH = 0 degenerates to a wire.
// Ports:
//   pclk  - pixel clock
//   reset - synchronous, active-high; clears every stage
//   i_d   - input word
//   o_q   - input word delayed by DEPTH cycles
module vga_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign o_q = i_d;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge pclk) begin
                if (reset) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= '0;
                    end
                end else begin
                    r_stage[0] <= i_d;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_text_ctrl.sv
// VGA timing generator and text-mode pixel pipeline.
// Stage 0 walks the raster, tracks the character cell incrementally and
// presents a VRAM cell index plus glyph line. Control is delayed RD_LAT
// cycles to meet the returning font row / attributes, then registered once,
// so sync, valid, RGB and strobes all leave RD_LAT+1 cycles after the address.
// Ports:
//   pclk, reset            - pixel clock, synchronous active-high reset
//   o_vram_addr            - cell index char_y*COLS+char_x (stage 0)
//   o_glyph_line           - line within the cell (stage 0)
//   i_glyph_bits           - font row, RD_LAT after address, MSB leftmost
//   i_fg_rgb, i_bg_rgb     - cell colours, RD_LAT after address
//   i_cursor_en/_x/_y      - cursor enable and cell position
//   o_hsync, o_vsync       - sync pulses, polarity set by SYNC_NEG
//   o_valid                - visible pixel
//   o_vga_r/_g/_b          - pixel colour
//   o_frame_start          - pulse on first visible pixel of a frame
//   o_line_start           - pulse on first visible pixel of each line
module vga_text_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = DEF_H_ACTIVE,
    parameter int unsigned H_FP         = DEF_H_FP,
    parameter int unsigned H_SYNC       = DEF_H_SYNC,
    parameter int unsigned H_BP         = DEF_H_BP,
    parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
    parameter int unsigned V_FP         = DEF_V_FP,
    parameter int unsigned V_SYNC       = DEF_V_SYNC,
    parameter int unsigned V_BP         = DEF_V_BP,
    parameter bit          SYNC_NEG     = DEF_SYNC_NEG,
    parameter int unsigned CHAR_W       = 9,
    parameter int unsigned CHAR_H       = 16,
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned BLINK_FRAMES = 30,
    localparam int unsigned COLS = H_ACTIVE / CHAR_W,
    localparam int unsigned ROWS = V_ACTIVE / CHAR_H,
    localparam int unsigned AW   = width_of(COLS * ROWS),
    localparam int unsigned CXW  = width_of(COLS),
    localparam int unsigned CYW  = width_of(ROWS),
    localparam int unsigned GLW  = width_of(CHAR_H)
) (
    input  logic              pclk,
    input  logic              reset,
    output logic [AW-1:0]     o_vram_addr,
    output logic [GLW-1:0]    o_glyph_line,
    input  logic [CHAR_W-1:0] i_glyph_bits,
    input  logic [23:0]       i_fg_rgb,
    input  logic [23:0]       i_bg_rgb,
    input  logic              i_cursor_en,
    input  logic [CXW-1:0]    i_cursor_x,
    input  logic [CYW-1:0]    i_cursor_y,
    output logic              o_hsync,
    output logic              o_vsync,
    output logic              o_valid,
    output logic [7:0]        o_vga_r,
    output logic [7:0]        o_vga_g,
    output logic [7:0]        o_vga_b,
    output logic              o_frame_start,
    output logic              o_line_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = width_of(H_TOTAL);
    localparam int unsigned VW      = width_of(V_TOTAL);
    localparam int unsigned PXW     = width_of(CHAR_W);
    localparam int unsigned FCW     = width_of(BLINK_FRAMES);
    localparam int unsigned CTRL_W  = 7 + PXW;

    localparam logic [HW-1:0]  H_END    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]  H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0]  H_PAD    = HW'(COLS * CHAR_W);
    localparam logic [HW-1:0]  H_SYNC_S = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]  H_SYNC_L = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0]  V_END    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]  V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0]  V_PAD    = VW'(ROWS * CHAR_H);
    localparam logic [VW-1:0]  V_SYNC_S = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]  V_SYNC_L = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [PXW-1:0] PX_LAST  = PXW'(CHAR_W - 1);
    localparam logic [GLW-1:0] GL_LAST  = GLW'(CHAR_H - 1);
    localparam logic [CXW-1:0] CX_LAST  = CXW'(COLS - 1);
    localparam logic [CYW-1:0] CY_LAST  = CYW'(ROWS - 1);
    localparam logic [AW-1:0]  ROW_STEP = AW'(COLS);
    localparam logic [FCW-1:0] FC_LAST  = FCW'(BLINK_FRAMES - 1);
    localparam logic           SYNC_IDLE = sync_level(1'b0, SYNC_NEG);

    // Raster and cell state
    logic [HW-1:0]  r_h_cnt;
    logic [VW-1:0]  r_v_cnt;
    logic [PXW-1:0] r_px_in_cell;
    logic [CXW-1:0] r_char_x;
    logic [GLW-1:0] r_line_in_cell;
    logic [CYW-1:0] r_char_y;
    logic [AW-1:0]  r_line_base;
    logic [FCW-1:0] r_frame_cnt;
    logic           r_blink_phase;

    // Output register
    logic           r_hsync;
    logic           r_vsync;
    logic           r_valid;
    rgb24_t         r_rgb;
    logic           r_frame_start;
    logic           r_line_start;

    // Stage 0 decode
    logic w_h_act, w_v_act, w_active, w_pad;
    logic w_h_wrap, w_v_wrap;
    logic w_hs_act, w_vs_act;
    logic w_cursor_hit, w_frame_stb, w_line_stb;

    always_comb begin
        w_h_act     = r_h_cnt < H_ACT;
        w_v_act     = r_v_cnt < V_ACT;
        w_active    = w_h_act && w_v_act;
        w_pad       = (r_h_cnt >= H_PAD) || (r_v_cnt >= V_PAD);
        w_h_wrap    = r_h_cnt == H_END;
        w_v_wrap    = w_h_wrap && (r_v_cnt == V_END);
        w_hs_act    = (r_h_cnt >= H_SYNC_S) && (r_h_cnt <= H_SYNC_L);
        w_vs_act    = (r_v_cnt >= V_SYNC_S) && (r_v_cnt <= V_SYNC_L);
        // char_x/char_y saturate at the last cell, so out-of-range cursor
        // coordinates can never compare equal
        w_cursor_hit = i_cursor_en && w_active && !w_pad &&
                       (r_char_x == i_cursor_x) && (r_char_y == i_cursor_y);
        w_frame_stb = (r_h_cnt == '0) && (r_v_cnt == '0);
        w_line_stb  = (r_h_cnt == '0) && w_v_act;
        o_vram_addr  = '0;
        o_glyph_line = '0;
        if (w_active) begin
            o_vram_addr  = r_line_base + AW'(r_char_x);
            o_glyph_line = r_line_in_cell;
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_h_cnt        <= '0;
            r_v_cnt        <= '0;
            r_px_in_cell   <= '0;
            r_char_x       <= '0;
            r_line_in_cell <= '0;
            r_char_y       <= '0;
            r_line_base    <= '0;
            r_frame_cnt    <= '0;
            r_blink_phase  <= 1'b1;
        end else begin
            r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + 1'b1;
            if (w_h_wrap) begin
                r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
            end

            // Horizontal cell walk; char_x holds at the last column in the pad
            if (w_h_wrap) begin
                r_px_in_cell <= '0;
                r_char_x     <= '0;
            end else if (w_h_act) begin
                if (r_px_in_cell == PX_LAST) begin
                    r_px_in_cell <= '0;
                    if (r_char_x != CX_LAST) begin
                        r_char_x <= r_char_x + 1'b1;
                    end
                end else begin
                    r_px_in_cell <= r_px_in_cell + 1'b1;
                end
            end

            // Vertical cell walk at the end of each active line
            if (w_v_wrap) begin
                r_line_in_cell <= '0;
                r_char_y       <= '0;
                r_line_base    <= '0;
            end else if (w_h_wrap && w_v_act) begin
                if (r_line_in_cell == GL_LAST) begin
                    r_line_in_cell <= '0;
                    if (r_char_y != CY_LAST) begin
                        r_char_y    <= r_char_y + 1'b1;
                        r_line_base <= r_line_base + ROW_STEP;
                    end
                end else begin
                    r_line_in_cell <= r_line_in_cell + 1'b1;
                end
            end

            if (w_v_wrap) begin
                if (r_frame_cnt == FC_LAST) begin
                    r_frame_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    // Align stage-0 control with the memory read latency
    logic [CTRL_W-1:0] w_ctrl_0, w_ctrl_d;
    logic              w_hs_d, w_vs_d, w_act_d, w_pad_d, w_hit_d, w_frame_d, w_line_d;
    logic [PXW-1:0]    w_px_d;

    assign w_ctrl_0 = {w_hs_act, w_vs_act, w_active, w_pad, w_cursor_hit,
                       w_frame_stb, w_line_stb, r_px_in_cell};

    vga_delay_line #(
        .WIDTH (CTRL_W),
        .DEPTH (RD_LAT)
    ) u_ctrl_dly (
        .pclk  (pclk),
        .reset (reset),
        .i_d   (w_ctrl_0),
        .o_q   (w_ctrl_d)
    );

    assign {w_hs_d, w_vs_d, w_act_d, w_pad_d, w_hit_d, w_frame_d, w_line_d, w_px_d} = w_ctrl_d;

    // Colour select; shifting left by px puts the wanted bit at the MSB
    logic [CHAR_W-1:0] w_glyph_shift;
    logic              w_use_fg;
    rgb24_t            w_color;

    always_comb begin
        w_glyph_shift = i_glyph_bits << w_px_d;
        w_use_fg      = w_glyph_shift[CHAR_W-1] ^ (w_hit_d && r_blink_phase);
        w_color       = w_use_fg ? i_fg_rgb : i_bg_rgb;
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_hsync       <= SYNC_IDLE;
            r_vsync       <= SYNC_IDLE;
            r_valid       <= 1'b0;
            r_rgb         <= '0;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
        end else begin
            r_hsync       <= sync_level(w_hs_d, SYNC_NEG);
            r_vsync       <= sync_level(w_vs_d, SYNC_NEG);
            r_valid       <= w_act_d;
            r_rgb         <= (w_act_d && !w_pad_d) ? w_color : '0;
            r_frame_start <= w_frame_d;
            r_line_start  <= w_line_d;
        end
    end

    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_valid       = r_valid;
    assign o_vga_r       = r_rgb[23:16];
    assign o_vga_g       = r_rgb[15:8];
    assign o_vga_b       = r_rgb[7:0];
    assign o_frame_start = r_frame_start;
    assign o_line_start  = r_line_start;

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Bench for vga_text_ctrl: two instances (RD_LAT=1 and RD_LAT=3) on a small
// raster, random VRAM/font contents, expected values from raster arithmetic.
module tb_vga_text_ctrl;

    localparam int HA = 40, HFP = 4, HS = 6, HBP = 5, HT = HA + HFP + HS + HBP;
    localparam int VA = 20, VFP = 2, VS = 2, VBP = 3, VT = VA + VFP + VS + VBP;
    localparam int CW = 9, CH = 6, COLS = HA / CW, ROWS = VA / CH, NCELL = COLS * ROWS;
    localparam int BF = 2, FT = HT * VT;
    localparam int LAT_A = 1, LAT_B = 3;

    logic        pclk = 1'b0;
    logic        reset = 1'b1;
    logic        cur_en;
    logic [1:0]  cur_x, cur_y;

    logic [3:0]  addr_a, addr_b;
    logic [2:0]  gl_a, gl_b;
    logic [8:0]  gb_a, gb_b;
    logic [23:0] fg_a, bg_a, fg_b, bg_b;
    logic        hs_a, vs_a, vld_a, fs_a, ls_a;
    logic        hs_b, vs_b, vld_b, fs_b, ls_b;
    logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;

    logic [8:0]  glyph_mem [NCELL][CH];
    logic [23:0] fg_mem [NCELL];
    logic [23:0] bg_mem [NCELL];
    logic [56:0] pipe_b [LAT_B];

    int n;
    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    vga_text_ctrl #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_NEG(1'b1), .CHAR_W(CW), .CHAR_H(CH), .RD_LAT(LAT_A), .BLINK_FRAMES(BF)
    ) dut_a (
        .pclk(pclk), .reset(reset),
        .o_vram_addr(addr_a), .o_glyph_line(gl_a),
        .i_glyph_bits(gb_a), .i_fg_rgb(fg_a), .i_bg_rgb(bg_a),
        .i_cursor_en(cur_en), .i_cursor_x(cur_x), .i_cursor_y(cur_y),
        .o_hsync(hs_a), .o_vsync(vs_a), .o_valid(vld_a),
        .o_vga_r(r_a), .o_vga_g(g_a), .o_vga_b(b_a),
        .o_frame_start(fs_a), .o_line_start(ls_a)
    );

    vga_text_ctrl #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_NEG(1'b1), .CHAR_W(CW), .CHAR_H(CH), .RD_LAT(LAT_B), .BLINK_FRAMES(BF)
    ) dut_b (
        .pclk(pclk), .reset(reset),
        .o_vram_addr(addr_b), .o_glyph_line(gl_b),
        .i_glyph_bits(gb_b), .i_fg_rgb(fg_b), .i_bg_rgb(bg_b),
        .i_cursor_en(cur_en), .i_cursor_x(cur_x), .i_cursor_y(cur_y),
        .o_hsync(hs_b), .o_vsync(vs_b), .o_valid(vld_b),
        .o_vga_r(r_b), .o_vga_g(g_b), .o_vga_b(b_b),
        .o_frame_start(fs_b), .o_line_start(ls_b)
    );

    function automatic logic [56:0] mem_word(input logic [3:0] a, input logic [2:0] l);
        if (int'(a) < NCELL && int'(l) < CH) return {glyph_mem[a][l], fg_mem[a], bg_mem[a]};
        return '0;
    endfunction

    // Synchronous memories with one and three cycles of read latency
    always @(posedge pclk) begin
        {gb_a, fg_a, bg_a} <= mem_word(addr_a, gl_a);
        pipe_b[0] <= mem_word(addr_b, gl_b);
        for (int k = 1; k < LAT_B; k++) pipe_b[k] <= pipe_b[k-1];
    end
    assign {gb_b, fg_b, bg_b} = pipe_b[LAT_B-1];

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s n=%0d: got %0h, expected %0h", name, n, got, exp);
        end
    endtask

    // n counts cycles since reset release; stage 0 shows raster position n,
    // the pins show position n-(lat+1)
    task automatic check_dut(input string tag, input int lat,
                             input logic hs, input logic vs, input logic vld,
                             input logic fs, input logic ls, input logic [23:0] rgb,
                             input logic [3:0] addr, input logic [2:0] gl);
        int p, h, v, f, cx, cy, a;
        logic e_hs, e_vs, e_vld, e_fs, e_ls, bit_v, inv, act;
        logic [23:0] e_rgb;
        p = n - (lat + 1);
        e_hs = 1'b1; e_vs = 1'b1; e_vld = 1'b0; e_fs = 1'b0; e_ls = 1'b0; e_rgb = '0;
        if (p >= 0) begin
            h = p % HT; v = (p / HT) % VT; f = p / FT;
            e_hs  = !(h >= HA + HFP && h < HA + HFP + HS);
            e_vs  = !(v >= VA + VFP && v < VA + VFP + VS);
            e_vld = (h < HA) && (v < VA);
            e_fs  = (h == 0) && (v == 0);
            e_ls  = (h == 0) && (v < VA);
            if (e_vld && h < COLS * CW && v < ROWS * CH) begin
                cx = h / CW; cy = v / CH; a = cy * COLS + cx;
                bit_v = glyph_mem[a][v % CH][CW - 1 - (h % CW)];
                inv = cur_en && (cx == int'(cur_x)) && (cy == int'(cur_y)) && ((f / BF) % 2 == 0);
                e_rgb = (bit_v ^ inv) ? fg_mem[a] : bg_mem[a];
            end
        end
        cmp({tag, ".hsync"}, 32'(hs), 32'(e_hs));
        cmp({tag, ".vsync"}, 32'(vs), 32'(e_vs));
        cmp({tag, ".valid"}, 32'(vld), 32'(e_vld));
        cmp({tag, ".frame_start"}, 32'(fs), 32'(e_fs));
        cmp({tag, ".line_start"}, 32'(ls), 32'(e_ls));
        cmp({tag, ".rgb"}, 32'(rgb), 32'(e_rgb));
        h = n % HT; v = (n / HT) % VT;
        act = (h < HA) && (v < VA);
        cx = h / CW; if (cx > COLS - 1) cx = COLS - 1;
        cy = v / CH; if (cy > ROWS - 1) cy = ROWS - 1;
        cmp({tag, ".vram_addr"}, 32'(addr), act ? 32'(cy * COLS + cx) : 32'd0);
        if (!act || v < ROWS * CH) cmp({tag, ".glyph_line"}, 32'(gl), act ? 32'(v % CH) : 32'd0);
    endtask

    task automatic check_all();
        check_dut("A", LAT_A, hs_a, vs_a, vld_a, fs_a, ls_a, {r_a, g_a, b_a}, addr_a, gl_a);
        check_dut("B", LAT_B, hs_b, vs_b, vld_b, fs_b, ls_b, {r_b, g_b, b_b}, addr_b, gl_b);
        // Corner pixel h=HA-1, v=VA-1 lies in both pads
        if (n == (VA - 1) * HT + HA - 1) cmp("A.corner_addr", 32'(addr_a), 32'd11);
        if (n == (VA - 1) * HT + HA - 1 + LAT_A + 1) begin
            cmp("A.corner_valid", 32'(vld_a), 32'd1);
            cmp("A.corner_rgb", 32'({r_a, g_a, b_a}), 32'd0);
        end
    endtask

    task automatic run(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge pclk);
            n++;
            check_all();
        end
    endtask

    task automatic pulse_reset(input logic en, input logic [1:0] x, input logic [1:0] y);
        reset = 1'b1;
        cur_en = en; cur_x = x; cur_y = y;
        @(negedge pclk);
        n = 0;
        reset = 1'b0;
        check_all();
    endtask

    initial begin
        for (int i = 0; i < NCELL; i++) begin
            for (int j = 0; j < CH; j++) glyph_mem[i][j] = 9'($urandom);
            fg_mem[i] = 24'($urandom);
            bg_mem[i] = 24'($urandom);
        end
        cur_en = 1'b1;
        cur_x = 2'($urandom_range(0, COLS - 1));
        cur_y = 2'($urandom_range(0, ROWS - 1));
        n = 0;
        repeat (3) @(negedge pclk);
        check_all();
        reset = 1'b0;
        check_all();
        // Six frames cover three blink half-periods, then reset mid-frame
        run(6 * FT + 10 * HT + 30);
        pulse_reset(1'b1, 2'($urandom_range(0, COLS - 1)), 2'd3);
        run(FT + 200);
        pulse_reset(1'b1, 2'd2, 2'd1);
        run(2 * FT + 100);
        pulse_reset(1'b0, 2'($urandom_range(0, COLS - 1)), 2'($urandom_range(0, ROWS - 1)));
        run(FT + 50);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_text_ctrl.md
Name: vga_text_ctrl

Overview:
- Parametrised VGA timing generator and text-mode pixel pipeline for the npc display path.
- Produces sync and blanking, a character-cell VRAM address and the glyph row for the font ROM. It realigns sync to the memory read latency and outputs 24-bit colour from per-cell fg/bg attributes.
- Adds a blinking, inverting cursor and frame/line strobes.
- Sits between the VRAM/font ROM and the VGA pins; timing and cell geometry are set by parameters rather than hard-coded.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- SYNC_NEG, 1, 1 = sync pulses active-low
- CHAR_W, 9, cell width in pixels
- CHAR_H, 16, cell height in lines
- RD_LAT, 1, VRAM/ROM read latency in cycles (0..4)
- BLINK_FRAMES, 30, frames per cursor blink half-period
- Derived: COLS=H_ACTIVE/CHAR_W, ROWS=V_ACTIVE/CHAR_H, AW=$clog2(COLS*ROWS), H_TOTAL, V_TOTAL

Ports:
- pclk, in, 1, pixel clock
- reset, in, 1, synchronous, active-high
- vram_addr, out, AW, cell index = char_y*COLS+char_x (stage 0)
- glyph_line, out, $clog2(CHAR_H), line within cell (stage 0)
- glyph_bits, in, CHAR_W, font row returned RD_LAT cycles after address; MSB = leftmost pixel
- fg_rgb, in, 24, foreground of the addressed cell (RD_LAT later)
- bg_rgb, in, 24, background of the addressed cell (RD_LAT later)
- cursor_en, in, 1, cursor enable
- cursor_x, in, $clog2(COLS), cursor column
- cursor_y, in, $clog2(ROWS), cursor row
- hsync, out, 1, horizontal sync (polarity per SYNC_NEG)
- vsync, out, 1, vertical sync
- valid, out, 1, visible pixel
- vga_r, out, 8, red
- vga_g, out, 8, green
- vga_b, out, 8, blue
- frame_start, out, 1, one-cycle pulse aligned with first visible pixel of a frame
- line_start, out, 1, one-cycle pulse aligned with first visible pixel of each line

Behaviour:
- Counters:
  - h_cnt runs 0..H_TOTAL-1. Order: active [0,H_ACTIVE), front porch, sync, back porch.
  - v_cnt increments when h_cnt wraps; it wraps at V_TOTAL-1 with the same region order.
- Cell tracking is incremental; no divider is used.
  - px_in_cell 0..CHAR_W-1 and char_x advance during active pixels, and are cleared when h_cnt wraps.
  - line_in_cell and char_y advance at the end of each active line, and are cleared at the v_cnt wrap.
  - A line_base register (+COLS per cell row) forms vram_addr; there is no multiplier.
- Partial cells:
  - Pixels with h >= COLS*CHAR_W or lines with v >= ROWS*CHAR_H are valid but shown as black.
  - vram_addr is held at the last in-range value during these pixels.
  - Outside the active region, vram_addr and glyph_line are 0.
- Alignment:
  - Stage 0 control (hsync, vsync, active, px_in_cell, cursor_hit, pad-blank, strobes) passes through an RD_LAT-deep shift register.
  - This is followed by one output register.
  - Total pixel latency, from address to pins, is RD_LAT+1 cycles, identical for sync, valid, RGB and strobes.
- Colour:
  - pix = glyph_bits[CHAR_W-1-px_d].
  - If cursor_hit_d && blink_phase, fg and bg are swapped.
  - Output is the selected 24-bit colour split r=[23:16], g=[15:8], b=[7:0].
  - RGB is 0 whenever the delayed active flag is 0 or the pixel is pad-blank.
- Cursor:
  - cursor_hit = cursor_en && char_x==cursor_x && char_y==cursor_y, evaluated at stage 0.
  - Out-of-range cursor coordinates never hit.
- Blink:
  - A frame counter increments at each v_cnt wrap.
  - At BLINK_FRAMES-1 it clears and toggles blink_phase.
  - blink_phase resets to 1 (cursor visible).
- Reset:
  - All counters, pipeline stages, blink state and outputs are cleared.
  - hsync and vsync go to the inactive level (1 if SYNC_NEG, else 0).
  - valid, RGB, frame_start, line_start and vram_addr are 0.
  - Reset asserted mid-frame restarts at h=0,v=0 on the first cycle after deassertion. The first frame_start appears RD_LAT+1 cycles later.
- Simultaneous h and v wrap: both counters wrap in the same cycle, and the frame counter updates exactly once.

Decomposition:
- Shared package vga_pkg holds:
  - the default 640x480@60 timing constants;
  - the rgb24 typedef;
  - the sync-polarity helper constant.
- One natural sub-module, vga_delay_line: a parametrised WIDTH×DEPTH shift register with synchronous reset, used for control alignment.

Test Plan:
- Defaults, reset released, run 1 frame -> hsync low for 96 cycles per line starting h=656+RD_LAT+1; vsync low on lines 490–491; 800×525 cycles per frame.
- glyph_bits=9'h100, fg=FFFFFF, bg=000000 -> first visible pixel of every cell white, other 8 black, at output cycle RD_LAT+1 after the address.
- Check vram_addr at h=639,v=479 -> 70+29*71=2129; pixel h=639 is pad-blank, so RGB=0 while valid=1.
- cursor_en=1, cursor=(2,1), BLINK_FRAMES=2 -> cell 73 inverted in frames 0–1, normal in frames 2–3, inverted in frames 4–5.
- RD_LAT=3 variant -> sync, valid and frame_start all shift by exactly 2 cycles relative to RD_LAT=1.
- Reset pulsed at h=300,v=200 -> next cycle outputs are idle; counting restarts at h=0,v=0; frame_start occurs RD_LAT+1 cycles after deassertion.
